cc_punct_enc: RTL
=================

Name: cc_punct_enc

Overview:
Parametrised convolutional encoder with 802.16 puncturing (rates 1/2, 2/3, 3/4, 5/6) for the FEC chain.
- Sits after the Reed-Solomon encoder and ahead of the interleaver.
- Generalises the fixed rate-1/2 encoder: configurable constraint length and generators, XOR (mod-2) generators, valid/ready handshakes on both sides, block framing, optional zero-tail flush.
- Serial: 1 bit in, 1 bit out per cycle.

Parameters:
- K, 7, constraint length; the shift register holds K-1 bits, K >= 3.
- G1, 7'o171, generator for the X output, K bits wide.
- G2, 7'o133, generator for the Y output, K bits wide.

Ports:
- clk  input  1  clock
- reset  input  1  reset, asynchronous, active-high
- in_bit  input  1  data bit
- in_valid  input  1  in_bit valid
- in_last  input  1  marks the final data bit of a block; qualified by in_valid
- in_ready  output  1  encoder accepts in_bit this cycle
- rate_id  input  2  0=1/2, 1=2/3, 2=3/4, 3=5/6; sampled at block start
- out_bit  output  1  coded bit
- out_valid  output  1  out_bit valid
- out_last  output  1  final coded bit of a block; qualified by out_valid
- out_ready  input  1  downstream accepts out_bit

Behaviour:
- Reset: shift reg s=0, pend=0, puncture phase=0, block_active=0, FSM=RUN; out_valid=0, out_bit=0, out_last=0, in_ready=0 during reset.
  - Reset mid-block discards all pending and in-flight data; no out_last is produced.
- Encoding, with s[0] the newest bit:
  - X = XOR over i of G1 bit [K-2-i] & s[i], XORed with G1[K-1] & u.
  - Y is computed the same way with G2.
  - u is the bit being encoded; on each encode step, s <= {s[K-3:0], u}.
- Puncture patterns are indexed by phase p; columns are listed X/Y; 1 = keep.
  - 1/2: period 1; X=1, Y=1.
  - 2/3: period 2; X=10, Y=11.
  - 3/4: period 3; X=101, Y=110.
  - 5/6: period 5; X=10101, Y=11010.
  - Every column keeps >= 1 bit.
  - Kept bits go into a 2-entry pending buffer, X before Y.
  - p increments per encoded bit, wraps at period-1 -> 0, and resets to 0 at block start.
- Rate latch: rate_id is captured on the first accepted bit while block_active=0. rate_id changes mid-block are ignored until the next block.
- Input handshake:
  - Transfer when in_valid & in_ready.
  - in_ready = (FSM==RUN) & (pend==0 | (pend==1 & out_ready)).
  - Encoded bits enter the pending buffer on the clock edge after the transfer.
- Output:
  - out_valid = (pend != 0); out_bit = head of pend.
  - Pops on out_valid & out_ready.
  - out_bit and out_last hold stable while out_valid=1 and out_ready=0.
- Throughput: with out_ready=1 held, rate 1/2 accepts 1 input per 2 cycles. Punctured-to-single columns allow 1 input per cycle.
- Latency: first coded bit appears on out_valid 1 cycle after the input transfer.
- Simultaneous events: a pop of the last pending bit and a push of a new column in the same cycle is legal; pend is set to the new column's count.
- FSM states:
  - RUN: accepts input. On accepting in_last, go to FLUSH if the feature is enabled, otherwise to DRAIN.
  - FLUSH: in_ready=0; encodes u=0 whenever pend allows; each tail bit uses the same puncture path with p continuing. After K-1 tail bits, go to DRAIN.
  - DRAIN: waits for pend==0, then clears s, p, block_active and returns to RUN.
- out_last: asserted with the last kept bit of the final encoded bit of the block. That is the last tail bit when the feature is enabled, otherwise the in_last bit.
- in_valid=0 mid-block: encoder idles; s and p are held; no timeout.

Optional Feature:
CC_ZERO_TAIL_EN
- Defined: after in_last, K-1 zero bits are encoded and punctured, so the encoder ends in state 0. The block emits (N+K-1) columns.
- Undefined: no flush; FLUSH is skipped and s is zeroed in DRAIN. The block emits N columns.

Test Plan:
- K=7, ZERO_TAIL_EN, rate 1/2, single bit 1 with in_last, out_ready=1 -> 14 bits 11 10 11 11 00 01 11; out_last on bit 14.
- Same impulse at rate 3/4 -> 10 bits 1 1 0 1 1 1 0 0 1 1; out_last on bit 10.
- Rate 1/2, 8-bit block with out_ready toggling 1 cycle on / 3 cycles off -> bitstream identical to the out_ready=1 run; out_bit stable while stalled; no bits lost or duplicated.
- rate_id changed from 0 to 3 mid-block -> whole block coded at 1/2. The next block codes at 5/6: 6 output bits per 5 input columns, phase reset to 0.
- Without ZERO_TAIL_EN, impulse at rate 1/2 -> exactly 2 bits 11 with out_last. The next block starts from state 0.
- Assert reset while pend==2 mid-block -> out_valid=0 immediately. A new block after release codes as if from power-up.

Source files
------------

// File: rtl/cc_punct_enc.sv
// Serial convolutional encoder with 802.16 puncturing (rates 1/2, 2/3, 3/4, 5/6).
// Define CC_ZERO_TAIL_EN to flush K-1 zero tail bits after each block.
module cc_punct_enc #(
    parameter int             K  = 7,
    parameter logic [K-1:0]   G1 = 7'o171,
    parameter logic [K-1:0]   G2 = 7'o133
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       in_bit,
    input  logic       in_valid,
    input  logic       in_last,
    output logic       in_ready,
    input  logic [1:0] rate_id,
    output logic       out_bit,
    output logic       out_valid,
    output logic       out_last,
    input  logic       out_ready
);

`ifdef CC_ZERO_TAIL_EN
    localparam bit ZERO_TAIL = 1'b1;
`else
    localparam bit ZERO_TAIL = 1'b0;
`endif
    localparam int TW = $clog2(K);

    typedef enum logic [1:0] {RUN, FLUSH, DRAIN} state_t;

    state_t         state_q, state_d;
    logic [K-2:0]   s_q, s_d;
    logic [1:0]     pend_cnt_q, pend_cnt_d;
    logic [1:0]     pend_bit_q, pend_bit_d;
    logic [1:0]     pend_last_q, pend_last_d;
    logic [2:0]     phase_q, phase_d;
    logic [1:0]     rate_q, rate_d;
    logic           act_q, act_d;
    logic [TW-1:0]  tail_q, tail_d;

    logic       room, pop, enc, u, x, y, keep_x, keep_y, col_last;
    logic [1:0] rate_eff;
    logic [2:0] period;

    assign out_valid = (pend_cnt_q != 2'd0);
    assign out_bit   = pend_bit_q[0];
    assign out_last  = out_valid & pend_last_q[0];

    always_comb begin
        pop      = out_valid & out_ready;
        // A new column may only land once the buffer is empty after this cycle's pop.
        room     = (pend_cnt_q == 2'd0) | ((pend_cnt_q == 2'd1) & out_ready);
        in_ready = ~reset & (state_q == RUN) & room;
        enc      = (state_q == RUN) ? (in_valid & in_ready) : ((state_q == FLUSH) & room);
        u        = (state_q == RUN) & in_bit;
        rate_eff = act_q ? rate_q : rate_id;

        x = G1[K-1] & u;
        y = G2[K-1] & u;
        for (int i = 0; i < K-1; i++) begin
            x = x ^ (G1[K-2-i] & s_q[i]);
            y = y ^ (G2[K-2-i] & s_q[i]);
        end

        period = 3'd1;
        keep_x = 1'b1;
        keep_y = 1'b1;
        case (rate_eff)
            2'd1: begin
                period = 3'd2;
                keep_x = (phase_q == 3'd0);
            end
            2'd2: begin
                period = 3'd3;
                keep_x = (phase_q != 3'd1);
                keep_y = (phase_q != 3'd2);
            end
            2'd3: begin
                period = 3'd5;
                keep_x = (phase_q == 3'd0) | (phase_q == 3'd2) | (phase_q == 3'd4);
                keep_y = (phase_q == 3'd0) | (phase_q == 3'd1) | (phase_q == 3'd3);
            end
            default: ;
        endcase

        col_last = (state_q == RUN) ? (in_last & ~ZERO_TAIL) : (tail_q == TW'(K-2));

        state_d     = state_q;
        s_d         = s_q;
        pend_cnt_d  = pend_cnt_q;
        pend_bit_d  = pend_bit_q;
        pend_last_d = pend_last_q;
        phase_d     = phase_q;
        rate_d      = rate_q;
        act_d       = act_q;
        tail_d      = tail_q;

        if (pop) begin
            if (pend_cnt_q == 2'd2) begin
                pend_cnt_d     = 2'd1;
                pend_bit_d[0]  = pend_bit_q[1];
                pend_last_d[0] = pend_last_q[1];
            end else begin
                pend_cnt_d = 2'd0;
            end
        end

        if (enc) begin
            s_d         = {s_q[K-3:0], u};
            phase_d     = (phase_q == period - 3'd1) ? 3'd0 : phase_q + 3'd1;
            pend_cnt_d  = {keep_x & keep_y, keep_x ^ keep_y};
            pend_bit_d  = {y, keep_x ? x : y};
            // out_last rides on whichever bit of the column is kept last.
            pend_last_d = {col_last, (keep_x & keep_y) ? 1'b0 : col_last};
        end

        case (state_q)
            RUN: begin
                if (enc) begin
                    if (!act_q) begin
                        rate_d = rate_id;
                        act_d  = 1'b1;
                    end
                    if (in_last) begin
                        state_d = ZERO_TAIL ? FLUSH : DRAIN;
                        tail_d  = '0;
                    end
                end
            end
            FLUSH: begin
                if (enc) begin
                    tail_d = tail_q + TW'(1);
                    if (tail_q == TW'(K-2)) state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (pend_cnt_q == 2'd0) begin
                    s_d     = '0;
                    phase_d = 3'd0;
                    act_d   = 1'b0;
                    state_d = RUN;
                end
            end
            default: state_d = RUN;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= RUN;
            s_q         <= '0;
            pend_cnt_q  <= 2'd0;
            pend_bit_q  <= 2'd0;
            pend_last_q <= 2'd0;
            phase_q     <= 3'd0;
            rate_q      <= 2'd0;
            act_q       <= 1'b0;
            tail_q      <= '0;
        end else begin
            state_q     <= state_d;
            s_q         <= s_d;
            pend_cnt_q  <= pend_cnt_d;
            pend_bit_q  <= pend_bit_d;
            pend_last_q <= pend_last_d;
            phase_q     <= phase_d;
            rate_q      <= rate_d;
            act_q       <= act_d;
            tail_q      <= tail_d;
        end
    end

endmodule
